// File: rtl/window_3x3_gen_if.sv
// Pixel-in / 3x3-window-out bus of the window generator.
// Optional WIN_FRAME_DONE_EN adds the frame_done last-window marker.
interface window_3x3_gen_if;
  logic [23:0] input_pixel;
  logic        input_is_valid;
  logic        sof;
  logic [23:0] output_pixel_1;
  logic [23:0] output_pixel_2;
  logic [23:0] output_pixel_3;
  logic [23:0] output_pixel_4;
  logic [23:0] output_pixel_5;
  logic [23:0] output_pixel_6;
  logic [23:0] output_pixel_7;
  logic [23:0] output_pixel_8;
  logic [23:0] output_pixel_9;
  logic        output_is_valid;
`ifdef WIN_FRAME_DONE_EN
  logic        frame_done;

  modport master (
    output input_pixel, input_is_valid, sof,
    input  output_pixel_1, output_pixel_2, output_pixel_3,
    input  output_pixel_4, output_pixel_5, output_pixel_6,
    input  output_pixel_7, output_pixel_8, output_pixel_9,
    input  output_is_valid, frame_done
  );

  modport slave (
    input  input_pixel, input_is_valid, sof,
    output output_pixel_1, output_pixel_2, output_pixel_3,
    output output_pixel_4, output_pixel_5, output_pixel_6,
    output output_pixel_7, output_pixel_8, output_pixel_9,
    output output_is_valid, frame_done
  );
`else
  modport master (
    output input_pixel, input_is_valid, sof,
    input  output_pixel_1, output_pixel_2, output_pixel_3,
    input  output_pixel_4, output_pixel_5, output_pixel_6,
    input  output_pixel_7, output_pixel_8, output_pixel_9,
    input  output_is_valid
  );

  modport slave (
    input  input_pixel, input_is_valid, sof,
    output output_pixel_1, output_pixel_2, output_pixel_3,
    output output_pixel_4, output_pixel_5, output_pixel_6,
    output output_pixel_7, output_pixel_8, output_pixel_9,
    output output_is_valid
  );
`endif
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3-column shift window.
// Optional macro WIN_FRAME_DONE_EN adds frame_done on the last window of a frame.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  window_3x3_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [23:0]   line_a_r [IMG_WIDTH];
  logic [23:0]   line_b_r [IMG_WIDTH];
  logic [23:0]   win_r    [9];
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic          valid_r;

  logic          accept_s;
  logic [CW-1:0] col_eff_s;
  logic [CW-1:0] col_next_s;
  logic [RW-1:0] row_eff_s;
  logic [RW-1:0] row_next_s;
  logic          win_hit_s;
  logic [23:0]   top_s;
  logic [23:0]   mid_s;

  // Position of the accepted pixel (sof forces (0,0)) and next counter values.
  always_comb begin
    accept_s = bus.input_is_valid;
    if (accept_s && bus.sof) begin
      col_eff_s = '0;
      row_eff_s = '0;
    end else begin
      col_eff_s = col_r;
      row_eff_s = row_r;
    end
    if (col_eff_s == COL_LAST) begin
      col_next_s = '0;
      if (row_eff_s == ROW_LAST) begin
        row_next_s = '0;
      end else begin
        row_next_s = row_eff_s + RW'(1);
      end
    end else begin
      col_next_s = col_eff_s + CW'(1);
      row_next_s = row_eff_s;
    end
    win_hit_s = (row_eff_s >= RW'(2)) && (col_eff_s >= CW'(2));
    top_s     = line_b_r[col_eff_s];
    mid_s     = line_a_r[col_eff_s];
  end

  // Line buffers: B takes the old line-A entry, A takes the new pixel.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_b_r[col_eff_s] <= line_a_r[col_eff_s];
      line_a_r[col_eff_s] <= bus.input_pixel;
    end
  end

  // Counters, window shift registers and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r   <= '0;
      row_r   <= '0;
      valid_r <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= 24'd0;
      end
    end else begin
      valid_r <= accept_s && win_hit_s;
      if (accept_s) begin
        col_r    <= col_next_s;
        row_r    <= row_next_s;
        win_r[0] <= win_r[1];
        win_r[1] <= win_r[2];
        win_r[2] <= top_s;
        win_r[3] <= win_r[4];
        win_r[4] <= win_r[5];
        win_r[5] <= mid_s;
        win_r[6] <= win_r[7];
        win_r[7] <= win_r[8];
        win_r[8] <= bus.input_pixel;
      end
    end
  end

`ifdef WIN_FRAME_DONE_EN
  logic frame_done_r;

  // The last window of a frame comes from the bottom-right input pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= accept_s && (row_eff_s == ROW_LAST) && (col_eff_s == COL_LAST);
    end
  end

  assign bus.frame_done = frame_done_r;
`endif

  assign bus.output_pixel_1  = win_r[0];
  assign bus.output_pixel_2  = win_r[1];
  assign bus.output_pixel_3  = win_r[2];
  assign bus.output_pixel_4  = win_r[3];
  assign bus.output_pixel_5  = win_r[4];
  assign bus.output_pixel_6  = win_r[5];
  assign bus.output_pixel_7  = win_r[6];
  assign bus.output_pixel_8  = win_r[7];
  assign bus.output_pixel_9  = win_r[8];
  assign bus.output_is_valid = valid_r;

endmodule
